stack_sequencer: RTL and testbench
==================================

// Module: stack_sequencer
// PURPOSE
//  Control FSM between the core's decode/PC logic and the 8-bit call/return Stack.
//  Turns CALL, RET and IRQ requests into Stack push/pop strobes and PC-load commands.
//  Tracks stack depth, because the Stack itself has no full/empty indication.
//  Blocks overflow and underflow, and masks nested interrupts until the ISR returns.
// PARAMETERS
//  DEPTH       16     usable Stack entries; depth counter range 0..DEPTH
//  AW          8      PC / return-address width
//  IRQ_VECTOR  8'hF0  PC loaded on interrupt entry
// PORTS
//  nclk        in   1      clock; all state updates on negedge, same edge as Stack
//  nreset      in   1      asynchronous active-low reset
//  call_req    in   1      CALL decoded this cycle; sampled only when !busy
//  ret_req     in   1      RET decoded this cycle; sampled only when !busy
//  irq_req     in   1      level interrupt request
//  call_target in   AW     CALL destination address
//  pc_ret      in   AW     return address (PC+1) to push
//  stk_top     in   AW     Stack data_out (current top)
//  stk_push    out  1      to Stack count_up
//  stk_pop     out  1      to Stack count_down
//  stk_data    out  AW     to Stack data_in
//  pc_load     out  1      one-cycle strobe: PC <= pc_next
//  pc_next     out  AW     PC value to load
//  busy        out  1      sequence in progress; core must stall fetch
//  in_isr      out  1      interrupt service active; further IRQs masked
//  depth       out  $clog2(DEPTH+1)  current entry count
//  err_ovf     out  1      sticky: push attempted at depth==DEPTH
//  err_unf     out  1      sticky: pop attempted at depth==0
//  err_clr     in   1      synchronous clear of both sticky error flags
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: stk_push, stk_pop, pc_load, busy, in_isr,
//   err_*, depth, stk_data, pc_next.
//  States: IDLE, POP, LOAD_RET.
//  Request priority in IDLE: irq (when !in_isr) > call > ret.
//   A lower-priority request that is not served is dropped; decode re-presents it.
//  CALL (IDLE, depth<DEPTH) is single-cycle:
//   - stk_push=1, stk_data=pc_ret, pc_load=1, pc_next=call_target, depth+1.
//   - Stays in IDLE; busy stays 0.
//  IRQ (IDLE, !in_isr, depth<DEPTH) is single-cycle:
//   - Same as CALL, but pc_next=IRQ_VECTOR; in_isr<=1.
//  RET (IDLE, depth>0):
//   - Cycle 1: stk_pop=1, depth-1, busy=1, go to POP.
//   - POP: wait one cycle for Stack pointer to settle; busy=1; go to LOAD_RET.
//   - LOAD_RET: pc_load=1, pc_next=stk_top, busy=1; in_isr<=0 if set; go to IDLE.
//   - Latency: RET request to pc_load is 3 edges.
//  Overflow (push request with depth==DEPTH):
//   - No stk_push, no pc_load; err_ovf<=1; IRQ stays pending.
//  Underflow (RET with depth==0):
//   - No stk_pop, no pc_load; err_unf<=1.
//  Strobe rules:
//   - stk_push, stk_pop and pc_load are one-cycle pulses.
//   - stk_push and stk_pop are never high together.
//  Request gating: requests are ignored while busy. irq_req stays pending (level).
//  err_clr has lower priority than a same-cycle error set (set wins).
//  nreset asserted mid-RET:
//   - Immediate return to IDLE, depth=0.
//   - Stack contents are considered invalid after reset.
// STRUCTURE
//  Shared package (uproc_pkg):
//   - State enum {IDLE, POP, LOAD_RET}.
//   - AW and the IRQ_VECTOR default.
//  Single flat module; the depth counter is inline, no sub-module.
// TESTING
//  1 CALL at pc_ret=8'h11, call_target=8'h40:
//    -> same edge stk_push=1, stk_data=8'h11, pc_load=1, pc_next=8'h40, depth=1.
//  2 Then RET with stk_top=8'h11:
//    -> stk_pop at edge 1, busy for 3 cycles, pc_load with pc_next=8'h11 at edge 3, depth=0.
//  3 16 CALLs, then a 17th:
//    -> depth=16, no push on the 17th, err_ovf=1.
//    -> err_clr clears it.
//  4 RET at depth 0 -> no pop, no pc_load, err_unf=1.
//  5 irq_req and call_req together at pc_ret=8'h22:
//    -> IRQ wins: pc_next=8'hF0, in_isr=1, CALL dropped.
//    -> Second irq ignored until RET; in_isr=0 after LOAD_RET.
//  6 nreset low during POP -> outputs 0, state IDLE, depth 0 immediately (async).

Source files
------------

// File: rtl/uproc_pkg.sv
// rtl/uproc_pkg.sv - shared types and defaults for the call/return stack sequencer
package uproc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_POP      = 2'd1,
        ST_LOAD_RET = 2'd2
    } state_t;

    localparam int         UPROC_AW         = 8;
    localparam logic [7:0] UPROC_IRQ_VECTOR = 8'hF0;

endpackage

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - CALL/RET/IRQ control FSM in front of a flagless call/return stack
module stack_sequencer
    import uproc_pkg::*;
#(
    parameter int            DEPTH      = 16,
    parameter int            AW         = UPROC_AW,
    parameter logic [AW-1:0] IRQ_VECTOR = AW'(UPROC_IRQ_VECTOR)
) (
    input  logic                         nclk,
    input  logic                         nreset,
    input  logic                         call_req,
    input  logic                         ret_req,
    input  logic                         irq_req,
    input  logic [AW-1:0]                call_target,
    input  logic [AW-1:0]                pc_ret,
    input  logic [AW-1:0]                stk_top,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [AW-1:0]                stk_data,
    output logic                         pc_load,
    output logic [AW-1:0]                pc_next,
    output logic                         busy,
    output logic                         in_isr,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err_ovf,
    output logic                         err_unf,
    input  logic                         err_clr
);

    localparam int            DW        = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_t        r_state;
    logic          r_stk_push;
    logic          r_stk_pop;
    logic [AW-1:0] r_stk_data;
    logic          r_pc_load;
    logic [AW-1:0] r_pc_next;
    logic          r_busy;
    logic          r_in_isr;
    logic [DW-1:0] r_depth;
    logic          r_err_ovf;
    logic          r_err_unf;

    logic w_idle_ok;
    logic w_irq_sel;
    logic w_call_sel;
    logic w_ret_sel;
    logic w_full;
    logic w_empty;
    logic w_push_go;
    logic w_pop_go;
    logic w_ovf_set;
    logic w_unf_set;

    // r_busy is still high for the cycle after LOAD_RET, so requests are only taken once it drops
    assign w_idle_ok  = (r_state == ST_IDLE) && !r_busy;
    assign w_irq_sel  = w_idle_ok && irq_req && !r_in_isr;
    assign w_call_sel = w_idle_ok && !w_irq_sel && call_req;
    assign w_ret_sel  = w_idle_ok && !w_irq_sel && !call_req && ret_req;

    assign w_full     = (r_depth == DEPTH_MAX);
    assign w_empty    = (r_depth == '0);
    assign w_push_go  = (w_irq_sel || w_call_sel) && !w_full;
    assign w_ovf_set  = (w_irq_sel || w_call_sel) && w_full;
    assign w_pop_go   = w_ret_sel && !w_empty;
    assign w_unf_set  = w_ret_sel && w_empty;

    always_ff @(negedge nclk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_IDLE;
            r_stk_push <= 1'b0;
            r_stk_pop  <= 1'b0;
            r_stk_data <= '0;
            r_pc_load  <= 1'b0;
            r_pc_next  <= '0;
            r_busy     <= 1'b0;
            r_in_isr   <= 1'b0;
            r_depth    <= '0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
        end else begin
            r_stk_push <= w_push_go;
            r_stk_pop  <= w_pop_go;
            r_pc_load  <= w_push_go || (r_state == ST_LOAD_RET);
            r_busy     <= w_pop_go || (r_state == ST_POP) || (r_state == ST_LOAD_RET);

            case (r_state)
                ST_IDLE:     r_state <= w_pop_go ? ST_POP : ST_IDLE;
                ST_POP:      r_state <= ST_LOAD_RET;
                ST_LOAD_RET: r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase

            if (w_push_go) begin
                r_stk_data <= pc_ret;
                r_pc_next  <= w_irq_sel ? IRQ_VECTOR : call_target;
                r_depth    <= r_depth + DW'(1);
            end else if (w_pop_go) begin
                r_depth    <= r_depth - DW'(1);
            end else if (r_state == ST_LOAD_RET) begin
                r_pc_next  <= stk_top;
            end

            if (w_irq_sel && !w_full) begin
                r_in_isr <= 1'b1;
            end else if (r_state == ST_LOAD_RET) begin
                r_in_isr <= 1'b0;
            end

            // a same-cycle error set takes precedence over err_clr
            if (w_ovf_set) begin
                r_err_ovf <= 1'b1;
            end else if (err_clr) begin
                r_err_ovf <= 1'b0;
            end

            if (w_unf_set) begin
                r_err_unf <= 1'b1;
            end else if (err_clr) begin
                r_err_unf <= 1'b0;
            end
        end
    end

    assign stk_push = r_stk_push;
    assign stk_pop  = r_stk_pop;
    assign stk_data = r_stk_data;
    assign pc_load  = r_pc_load;
    assign pc_next  = r_pc_next;
    assign busy     = r_busy;
    assign in_isr   = r_in_isr;
    assign depth    = r_depth;
    assign err_ovf  = r_err_ovf;
    assign err_unf  = r_err_unf;

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - scoreboard bench for stack_sequencer with a transaction-level stack model
module tb_stack_sequencer;

    logic       nclk = 1'b1;
    logic       nreset = 1'b0;
    logic       call_req = 1'b0;
    logic       ret_req = 1'b0;
    logic       irq_req = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] call_target = '0;
    logic [7:0] pc_ret = '0;
    logic [7:0] stk_top = '0;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_data;
    logic       pc_load;
    logic [7:0] pc_next;
    logic       busy;
    logic       in_isr;
    logic [4:0] depth;
    logic       err_ovf;
    logic       err_unf;

    stack_sequencer dut (
        .nclk        (nclk),
        .nreset      (nreset),
        .call_req    (call_req),
        .ret_req     (ret_req),
        .irq_req     (irq_req),
        .call_target (call_target),
        .pc_ret      (pc_ret),
        .stk_top     (stk_top),
        .stk_push    (stk_push),
        .stk_pop     (stk_pop),
        .stk_data    (stk_data),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .busy        (busy),
        .in_isr      (in_isr),
        .depth       (depth),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf),
        .err_clr     (err_clr)
    );

    always #5 nclk = ~nclk;

    typedef struct {
        bit         push;
        bit         pop;
        bit         load;
        logic [7:0] data;
        logic [7:0] next;
        int         dep;
    } ev_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    ev_t        exp_q[$];
    logic [7:0] mstack[$];
    bit         m_isr = 0;
    bit         m_ovf = 0;
    bit         m_unf = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every strobe the DUT shows is matched against the oldest expected event
    always @(posedge nclk) begin : monitor
        ev_t e;
        if (nreset && (stk_push || stk_pop || pc_load)) begin
            check("push_pop_exclusive", 32'(stk_push && stk_pop), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({stk_push, stk_pop, pc_load}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_strobes", 32'({stk_push, stk_pop, pc_load}), 32'({e.push, e.pop, e.load}));
                if (e.push) check("event_stk_data", 32'(stk_data), 32'(e.data));
                if (e.load) check("event_pc_next", 32'(pc_next), 32'(e.next));
                check("event_depth", 32'(depth), 32'(e.dep));
            end
        end
    end

    task automatic push_ev(input bit pu, input bit po, input bit ld, input logic [7:0] d, input logic [7:0] n);
        ev_t e;
        e.push = pu; e.pop = po; e.load = ld; e.data = d; e.next = n; e.dep = mstack.size();
        exp_q.push_back(e);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_depth"},   32'(depth),   32'(mstack.size()));
        check({tag, "_in_isr"},  32'(in_isr),  32'(m_isr));
        check({tag, "_err_ovf"}, 32'(err_ovf), 32'(m_ovf));
        check({tag, "_err_unf"}, 32'(err_unf), 32'(m_unf));
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_op(input bit c, input bit r, input bit i, input bit clr,
                         input logic [7:0] pc, input logic [7:0] tgt, input string tag);
        bit set_o = 0;
        bit set_u = 0;
        bit long_seq = 0;
        logic [7:0] v;
        @(posedge nclk);
        call_req = c; ret_req = r; irq_req = i; err_clr = clr;
        pc_ret = pc; call_target = tgt;
        if (i && !m_isr) begin
            if (mstack.size() < 16) begin
                mstack.push_back(pc);
                m_isr = 1;
                push_ev(1, 0, 1, pc, 8'hF0);
            end else set_o = 1;
        end else if (c) begin
            if (mstack.size() < 16) begin
                mstack.push_back(pc);
                push_ev(1, 0, 1, pc, tgt);
            end else set_o = 1;
        end else if (r) begin
            if (mstack.size() > 0) begin
                v = mstack.pop_back();
                stk_top = v;
                push_ev(0, 1, 0, 8'h00, 8'h00);
                push_ev(0, 0, 1, 8'h00, v);
                long_seq = 1;
            end else set_u = 1;
        end
        if (set_o) m_ovf = 1; else if (clr) m_ovf = 0;
        if (set_u) m_unf = 1; else if (clr) m_unf = 0;
        @(posedge nclk);
        call_req = 0; ret_req = 0; irq_req = 0; err_clr = 0;
        if (long_seq) begin
            // junk requests during the RET sequence must be ignored
            call_req = 1'($urandom_range(0, 1));
            irq_req = 1'($urandom_range(0, 1));
            call_target = 8'($urandom);
            check({tag, "_busy1"}, 32'(busy), 32'd1);
            @(posedge nclk);
            check({tag, "_busy2"}, 32'(busy), 32'd1);
            @(posedge nclk);
            check({tag, "_busy3"}, 32'(busy), 32'd1);
            @(posedge nclk);
            call_req = 0; irq_req = 0;
            m_isr = 0;
        end
        @(posedge nclk);
        check_state(tag);
    endtask

    task automatic reset_mid_ret();
        if (mstack.size() == 0) do_op(1, 0, 0, 0, 8'h5A, 8'h77, "rst_pre");
        @(posedge nclk);
        ret_req = 1;
        stk_top = mstack[mstack.size() - 1];
        void'(mstack.pop_back());
        push_ev(0, 1, 0, 8'h00, 8'h00);
        @(posedge nclk);
        ret_req = 0;
        check("rst_in_pop_busy", 32'(busy), 32'd1);
        #2;
        nreset = 0;
        #1;
        check("rst_async_strobes", 32'({stk_push, stk_pop, pc_load, busy, in_isr, err_ovf, err_unf}), 32'd0);
        check("rst_async_depth", 32'(depth), 32'd0);
        check("rst_async_pc_next", 32'(pc_next), 32'd0);
        check("rst_async_stk_data", 32'(stk_data), 32'd0);
        mstack.delete();
        exp_q.delete();
        m_isr = 0; m_ovf = 0; m_unf = 0;
        repeat (3) @(posedge nclk);
        nreset = 1;
        repeat (4) @(posedge nclk);
        check_state("rst_after");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge nclk);
        check("reset_flags", 32'({stk_push, stk_pop, pc_load, busy, in_isr, err_ovf, err_unf}), 32'd0);
        check("reset_depth", 32'(depth), 32'd0);
        check("reset_stk_data", 32'(stk_data), 32'd0);
        check("reset_pc_next", 32'(pc_next), 32'd0);
        nreset = 1;
        @(posedge nclk);

        do_op(1, 0, 0, 0, 8'h11, 8'h40, "call_basic");
        do_op(0, 1, 0, 0, 8'h00, 8'h00, "ret_basic");

        for (int k = 0; k < 17; k++) do_op(1, 0, 0, 0, 8'($urandom), 8'($urandom), "fill");
        do_op(0, 0, 0, 1, 8'h00, 8'h00, "ovf_clr");
        for (int k = 0; k < 16; k++) do_op(0, 1, 0, 0, 8'h00, 8'h00, "drain");

        do_op(0, 1, 0, 0, 8'h00, 8'h00, "unf");
        do_op(1, 0, 0, 1, 8'h3C, 8'h81, "clr_with_call");

        do_op(1, 0, 1, 0, 8'h22, 8'h55, "irq_wins");
        do_op(0, 0, 1, 0, 8'h00, 8'h00, "irq_masked");
        do_op(1, 0, 1, 0, 8'h33, 8'h66, "irq_masked_call");
        do_op(0, 1, 0, 0, 8'h00, 8'h00, "isr_ret1");
        do_op(0, 0, 1, 0, 8'h44, 8'h00, "irq_again");
        do_op(0, 1, 0, 0, 8'h00, 8'h00, "isr_ret2");
        do_op(0, 1, 0, 0, 8'h00, 8'h00, "isr_ret3");

        reset_mid_ret();

        for (int k = 0; k < 300; k++) begin
            bit c, r, i, cl;
            c  = $urandom_range(0, 99) < ((k < 150) ? 60 : 25);
            r  = $urandom_range(0, 99) < ((k < 150) ? 30 : 65);
            i  = $urandom_range(0, 99) < 15;
            cl = $urandom_range(0, 7) == 0;
            do_op(c, r, i, cl, 8'($urandom), 8'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
